mem_1r1w_masked_ctrl: RTL and testbench
=======================================

Name: mem_1r1w_masked_ctrl

Overview:
- Sequencer and arbiter in front of one 1R1W byte-masked memory macro (DEPTH x 64b, 8b mask granularity, read latency 1).
- After reset, zero-fills every entry.
- Then shares the macro between two requesters, with independent round-robin arbitration of the read port and the write port.
- Forwards same-cycle write data into colliding reads, so clients never see the macro's undefined read-during-write result.

Parameters:
- DEPTH, 48, number of memory entries.
- AW, 6, address width, ceil(log2(DEPTH)).
- DW, 64, data width.
- MW, 8, mask width, DW/8.

Ports:
- clock  in  1  single clock; the macro's R0_clk and W0_clk are tied to it at top level
- reset_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  request valid, N=0,1
- reqN_ready  out  1  request accepted this cycle (combinational grant)
- reqN_write  in  1  1=write, 0=read
- reqN_addr  in  AW  entry address
- reqN_wdata  in  DW  write data
- reqN_wmask  in  MW  byte write enables
- rspN_valid  out  1  read response valid; no backpressure
- rspN_data  out  DW  read data
- rspN_err  out  1  read address was out of range
- init_busy  out  1  zero-fill in progress
- R0_addr  out  AW  macro read address
- R0_en  out  1  macro read enable
- R0_data  in  DW  macro read data, valid the cycle after R0_en
- W0_addr  out  AW  macro write address
- W0_en  out  1  macro write enable
- W0_data  out  DW  macro write data
- W0_mask  out  MW  macro byte mask

Behaviour:
- Reset values: init_busy=1, all ready/rsp_valid/rsp_err=0, rsp_data=0, R0_en=W0_en=0, both RR pointers=0, init counter=0.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle drives W0_en=1, W0_addr=cnt, W0_data=0, W0_mask=all ones; cnt increments.
  - Leaves for RUN the cycle after the write of addr DEPTH-1; exactly DEPTH write cycles.
  - init_busy=1 and reqN_ready=0 throughout; R0_en=0.
- RUN: init_busy=0; two independent ports per cycle.
  - Write contenders: valid && write. Read contenders: valid && !write.
  - One requester may read while the other writes in the same cycle.
- Arbitration, per port:
  - Sole contender is granted.
  - If both contend, the requester named by that port's RR pointer is granted.
  - After any grant on a port, its pointer becomes the non-granted index.
  - reqN_ready = granted, purely combinational from the valids and pointers.
  - A request with no grant must be held by the client; this block keeps no queue.
- Write grant:
  - In range (addr < DEPTH): W0_en=1 with the granted addr, data and mask, same cycle.
  - Out of range: accepted (ready=1), W0_en=0, dropped silently.
  - Writes are posted; no response.
- Read grant:
  - In range: R0_en=1 and R0_addr=addr, same cycle.
  - Response one cycle later on the granting requester: rspN_valid=1 for exactly one cycle, rspN_data from R0_data (after merge), rspN_err=0.
  - Out of range: R0_en=0; next cycle rspN_valid=1, rspN_err=1, rspN_data=0.
- Collision forwarding:
  - Condition: read and write granted in the same cycle to the same in-range address.
  - The write's mask and data are registered.
  - Next cycle, response byte i = wmask_q[i] ? wdata_q byte i : R0_data byte i.
  - No forwarding across cycles: the macro is write-first for later cycles.
- Mask=0 write: W0_en=1 with mask 0; memory is unchanged.
- Asynchronous reset at any time:
  - All state returns to reset values immediately.
  - In-flight responses are lost.
  - Zero-fill restarts at addr 0.

Test Plan:
- Release reset -> init_busy=1 for exactly 48 cycles; W0 sweeps addr 0..47 with data 0 and mask 0xFF; ready=0 throughout.
  - Then a read of addr 47 -> rsp data 0, err 0.
- req0 writes addr 5, data 0x1122334455667788, mask 0xFF; next cycle req1 reads addr 5.
  - Required: rsp1_valid one cycle after grant, data 0x1122334455667788.
- Both requesters continuously read addr 1 and addr 2 -> grants alternate 0,1,0,1 starting with req0.
  - Write port pointer is unaffected.
- Same cycle: req0 writes addr 9, data 0xAAAAAAAAAAAAAAAA, mask 0x0F; req1 reads addr 9; memory addr 9 holds 0x1111111111111111.
  - Required: rsp1_data = 0x11111111AAAAAAAA.
- req1 reads addr 50 -> R0_en=0; next cycle rsp1_valid=1, err=1, data 0.
  - req0 write to addr 63 -> ready=1, W0_en=0.
- Assert reset_n=0 during RUN with a read outstanding -> rsp_valid=0, init_busy=1 immediately.
  - After release, full 48-cycle zero-fill repeats and previously written data reads back 0.

Source files
------------

// File: rtl/mem_1r1w_masked_ctrl.sv
// Sequencer/arbiter for a 1R1W byte-masked memory macro: zero-fills after reset, then
// round-robins two requesters independently on the read and write ports.
module mem_1r1w_masked_ctrl #(
  parameter int DEPTH = 48,
  parameter int AW    = 6,
  parameter int DW    = 64,
  parameter int MW    = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [MW-1:0] req0_wmask,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [MW-1:0] req1_wmask,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp0_err,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp1_err,
  output logic          init_busy,
  output logic [AW-1:0] R0_addr,
  output logic          R0_en,
  input  logic [DW-1:0] R0_data,
  output logic [AW-1:0] W0_addr,
  output logic          W0_en,
  output logic [DW-1:0] W0_data,
  output logic [MW-1:0] W0_mask
);

  localparam logic [0:0]    ST_INIT = 1'b0;
  localparam logic [0:0]    ST_RUN  = 1'b1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          rsp_v_q, rsp_v_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [MW-1:0] fwd_mask_q, fwd_mask_d;
  logic [DW-1:0] fwd_data_q, fwd_data_d;

  logic          run;
  logic          wr_c0, wr_c1, rd_c0, rd_c1;
  logic          wr_any, rd_any, wr_gnt, rd_gnt;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, merged, rsp_data;
  logic [MW-1:0] wr_mask;
  logic          wr_inr, rd_inr, wr_fire, rd_fire;

  assign run    = (state_q == ST_RUN);
  assign wr_c0  = run & req0_valid & req0_write;
  assign wr_c1  = run & req1_valid & req1_write;
  assign rd_c0  = run & req0_valid & ~req0_write;
  assign rd_c1  = run & req1_valid & ~req1_write;
  assign wr_any = wr_c0 | wr_c1;
  assign rd_any = rd_c0 | rd_c1;
  // With both contending the pointer picks; otherwise the sole contender (req1 iff only it).
  assign wr_gnt = (wr_c0 & wr_c1) ? wr_ptr_q : wr_c1;
  assign rd_gnt = (rd_c0 & rd_c1) ? rd_ptr_q : rd_c1;

  assign req0_ready = (wr_any & ~wr_gnt) | (rd_any & ~rd_gnt);
  assign req1_ready = (wr_any &  wr_gnt) | (rd_any &  rd_gnt);

  assign wr_addr = wr_gnt ? req1_addr  : req0_addr;
  assign wr_data = wr_gnt ? req1_wdata : req0_wdata;
  assign wr_mask = wr_gnt ? req1_wmask : req0_wmask;
  assign rd_addr = rd_gnt ? req1_addr  : req0_addr;
  assign wr_inr  = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_inr  = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_fire = wr_any & wr_inr;
  assign rd_fire = rd_any & rd_inr;

  assign init_busy = ~run;
  assign R0_en     = rd_fire;
  assign R0_addr   = rd_addr;

  // Zero-fill write is gated by reset_n so the macro sees no write while reset is held.
  always_comb begin
    W0_en   = wr_fire;
    W0_addr = wr_addr;
    W0_data = wr_data;
    W0_mask = wr_mask;
    if (!run) begin
      W0_en   = reset_n;
      W0_addr = cnt_q;
      W0_data = '0;
      W0_mask = '1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rsp_v_d    = rd_any;
    rsp_id_d   = rd_gnt;
    rsp_err_d  = rd_any & ~rd_inr;
    fwd_mask_d = (rd_fire && wr_fire && (rd_addr == wr_addr)) ? wr_mask : '0;
    fwd_data_d = wr_data;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
    if (wr_any) wr_ptr_d = ~wr_gnt;
    if (rd_any) rd_ptr_d = ~rd_gnt;
  end

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      merged[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8] : R0_data[8*i +: 8];
    end
    rsp_data = (rsp_v_q && !rsp_err_q) ? merged : '0;
  end

  assign rsp0_valid = rsp_v_q & ~rsp_id_q;
  assign rsp1_valid = rsp_v_q &  rsp_id_q;
  assign rsp0_err   = rsp0_valid & rsp_err_q;
  assign rsp1_err   = rsp1_valid & rsp_err_q;
  assign rsp0_data  = rsp_id_q ? '0 : rsp_data;
  assign rsp1_data  = rsp_id_q ? rsp_data : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rsp_v_q    <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rsp_v_q    <= rsp_v_d;
      rsp_id_q   <= rsp_id_d;
      rsp_err_q  <= rsp_err_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

endmodule

// File: tb/tb_mem_1r1w_masked_ctrl.sv
// Directed bench for mem_1r1w_masked_ctrl with a behavioural 1R1W macro whose
// read-during-write bytes return X.
module tb_mem_1r1w_masked_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_write, req1_valid, req1_ready, req1_write;
  logic [5:0]  req0_addr, req1_addr;
  logic [63:0] req0_wdata, req1_wdata;
  logic [7:0]  req0_wmask, req1_wmask;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err, init_busy;
  logic [63:0] rsp0_data, rsp1_data;
  logic [5:0]  R0_addr, W0_addr;
  logic        R0_en, W0_en;
  logic [63:0] R0_data, W0_data;
  logic [7:0]  W0_mask;

  int n_assert = 0;
  int n_fail   = 0;

  mem_1r1w_masked_ctrl #(.DEPTH(48), .AW(6), .DW(64), .MW(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wmask(req0_wmask),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wmask(req1_wmask),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .init_busy(init_busy),
    .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
    .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
  );

  always #5 clock = ~clock;

  logic [63:0] mem [0:63];
  always @(posedge clock) begin
    if (R0_en) begin
      for (int i = 0; i < 8; i++) begin
        R0_data[8*i +: 8] <= (W0_en && W0_addr == R0_addr && W0_mask[i]) ? 8'hxx
                                                                           : mem[R0_addr][8*i +: 8];
      end
    end
    if (W0_en) begin
      for (int j = 0; j < 8; j++) begin
        if (W0_mask[j]) mem[W0_addr][8*j +: 8] <= W0_data[8*j +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
  endtask

  task automatic rd(input int r, input logic [5:0] a);
    if (r == 0) begin req0_valid = 1'b1; req0_write = 1'b0; req0_addr = a; end
    else        begin req1_valid = 1'b1; req1_write = 1'b0; req1_addr = a; end
  endtask

  task automatic wr(input int r, input logic [5:0] a, input logic [63:0] d, input logic [7:0] m);
    if (r == 0) begin req0_valid = 1'b1; req0_write = 1'b1; req0_addr = a; req0_wdata = d; req0_wmask = m; end
    else        begin req1_valid = 1'b1; req1_write = 1'b1; req1_addr = a; req1_wdata = d; req1_wmask = m; end
  endtask

  // Called on the negedge right after reset release; returns on the negedge after fill.
  task automatic check_fill();
    for (int i = 0; i < 48; i++) begin
      #1;
      check("init_busy", 64'(init_busy), 64'd1);
      check("init_w0_en", 64'(W0_en), 64'd1);
      check("init_w0_addr", 64'(W0_addr), 64'(i));
      check("init_w0_data", W0_data, 64'd0);
      check("init_w0_mask", 64'(W0_mask), 64'hFF);
      check("init_ready", 64'({req0_ready, req1_ready}), 64'd0);
      check("init_r0_en", 64'(R0_en), 64'd0);
      @(negedge clock);
    end
    idle();
    #1;
    check("init_done", 64'(init_busy), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (2) @(posedge clock);
    #1;
    check("rst_init_busy", 64'(init_busy), 64'd1);
    check("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
    check("rst_rsp_valid", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    check("rst_rsp_err", 64'({rsp0_err, rsp1_err}), 64'd0);
    check("rst_rsp0_data", rsp0_data, 64'd0);
    check("rst_rsp1_data", rsp1_data, 64'd0);
    check("rst_w0_en", 64'(W0_en), 64'd0);
    check("rst_r0_en", 64'(R0_en), 64'd0);

    // Requests held during fill must not be accepted.
    rd(0, 6'd3);
    wr(1, 6'd4, 64'hDEAD, 8'hFF);
    @(negedge clock);
    reset_n = 1'b1;
    check_fill();

    // Read of last entry after fill.
    rd(0, 6'd47);
    #1;
    check("rd47_ready", 64'(req0_ready), 64'd1);
    check("rd47_r0", 64'({R0_en, R0_addr}), 64'({1'b1, 6'd47}));
    @(posedge clock); #1;
    check("rd47_rsp", 64'({rsp0_valid, rsp0_err, rsp1_valid}), 64'b100);
    check("rd47_data", rsp0_data, 64'd0);

    // Write then read-back on the other requester.
    @(negedge clock); idle();
    wr(0, 6'd5, 64'h1122334455667788, 8'hFF);
    #1;
    check("wr5_ready", 64'(req0_ready), 64'd1);
    check("wr5_w0", 64'({W0_en, W0_addr, W0_mask}), 64'({1'b1, 6'd5, 8'hFF}));
    check("wr5_w0_data", W0_data, 64'h1122334455667788);
    @(posedge clock); #1;
    check("wr5_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    @(negedge clock); idle();
    rd(1, 6'd5);
    #1;
    check("rd5_ready", 64'({req0_ready, req1_ready}), 64'b01);
    @(posedge clock); #1;
    check("rd5_rsp", 64'({rsp1_valid, rsp1_err, rsp0_valid}), 64'b100);
    check("rd5_data", rsp1_data, 64'h1122334455667788);
    @(negedge clock); idle();
    @(posedge clock); #1;
    check("rd5_one_cycle", 64'(rsp1_valid), 64'd0);

    // Both read continuously: grants 0,1,0,1.
    @(negedge clock);
    rd(0, 6'd1);
    rd(1, 6'd2);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready", 64'({req0_ready, req1_ready}), (k % 2 == 0) ? 64'b10 : 64'b01);
      check("rr_r0_addr", 64'(R0_addr), (k % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_w0_en", 64'(W0_en), 64'd0);
      @(posedge clock); #1;
      check("rr_rsp", 64'({rsp0_valid, rsp1_valid}), (k % 2 == 0) ? 64'b10 : 64'b01);
      check("rr_data", rsp0_data | rsp1_data, 64'd0);
      @(negedge clock);
    end

    // Write pointer was last moved to 1 by the req0 write.
    idle();
    wr(0, 6'd9, 64'h1111111111111111, 8'hFF);
    wr(1, 6'd10, 64'h2222222222222222, 8'hFF);
    #1;
    check("wrr_first", 64'({req0_ready, req1_ready, W0_addr}), 64'({2'b01, 6'd10}));
    @(negedge clock);
    req1_valid = 1'b0;
    req1_valid = 1'b1;
    #1;
    check("wrr_second", 64'({req0_ready, req1_ready, W0_addr}), 64'({2'b10, 6'd9}));
    check("wrr_second_data", W0_data, 64'h1111111111111111);
    @(negedge clock); idle();

    // Collision: write addr 9 mask 0x0F with read addr 9 in the same cycle.
    wr(0, 6'd9, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    rd(1, 6'd9);
    #1;
    check("col_ready", 64'({req0_ready, req1_ready}), 64'b11);
    check("col_ports", 64'({W0_en, R0_en, W0_addr, R0_addr}), 64'({2'b11, 6'd9, 6'd9}));
    @(posedge clock); #1;
    check("col_rsp", 64'({rsp1_valid, rsp1_err}), 64'b10);
    check("col_data", rsp1_data, 64'h11111111AAAAAAAA);
    @(negedge clock); idle();
    rd(1, 6'd9);
    @(posedge clock); #1;
    check("col_later", rsp1_data, 64'h11111111AAAAAAAA);

    // Mask-0 write leaves memory unchanged.
    @(negedge clock); idle();
    wr(0, 6'd9, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    #1;
    check("m0_w0", 64'({W0_en, W0_mask}), 64'({1'b1, 8'h00}));
    @(negedge clock); idle();
    rd(0, 6'd9);
    @(posedge clock); #1;
    check("m0_data", rsp0_data, 64'h11111111AAAAAAAA);

    // Out-of-range read and write.
    @(negedge clock); idle();
    rd(1, 6'd50);
    wr(0, 6'd63, 64'h5555, 8'hFF);
    #1;
    check("oor_ready", 64'({req0_ready, req1_ready}), 64'b11);
    check("oor_en", 64'({R0_en, W0_en}), 64'b00);
    @(posedge clock); #1;
    check("oor_rsp", 64'({rsp1_valid, rsp1_err, rsp0_valid, rsp0_err}), 64'b1100);
    check("oor_data", rsp1_data, 64'd0);

    // Reset with a response outstanding.
    @(negedge clock); idle();
    rd(0, 6'd5);
    @(posedge clock); #1;
    check("pre_rst_rsp", 64'(rsp0_valid), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
    check("mid_rst_busy", 64'(init_busy), 64'd1);
    check("mid_rst_ready", 64'(req0_ready), 64'd0);
    check("mid_rst_w0_en", 64'(W0_en), 64'd0);
    @(negedge clock);
    idle();
    reset_n = 1'b1;
    check_fill();

    rd(0, 6'd5);
    @(posedge clock); #1;
    check("post_rst_5", 64'({rsp0_valid, rsp0_err}), 64'b10);
    check("post_rst_5_data", rsp0_data, 64'd0);
    @(negedge clock); idle();
    rd(1, 6'd9);
    @(posedge clock); #1;
    check("post_rst_9_data", rsp1_data, 64'd0);
    @(negedge clock); idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
